// File: rtl/durum_desen_algilayici.sv
// Serial pattern detector: runtime pattern/mask, valid qualifier,
// overlap mode select and a saturating match counter.
module durum_desen_algilayici #(
  parameter int unsigned N                  = 4,
  parameter int unsigned SAYAC_GENISLIK     = 8,
  parameter logic [N-1:0] VARSAYILAN_DESEN  = 4'b1101,
  parameter logic [N-1:0] VARSAYILAN_MASKE  = 4'b0000
) (
  input  logic                      saat,
  input  logic                      reset,
  input  logic                      giris,
  input  logic                      gecerli,
  input  logic                      cakisma,
  input  logic                      desen_yukle,
  input  logic [N-1:0]              desen,
  input  logic [N-1:0]              maske,
  output logic                      cikis,
  output logic [SAYAC_GENISLIK-1:0] eslesme_sayisi,
  output logic [$clog2(N+1)-1:0]    durum_no
);

  localparam int unsigned DW = $clog2(N + 1);
  localparam logic [DW-1:0] DOLU = DW'(N);

  typedef enum logic [1:0] {
    BOS,
    DOLUM,
    HAZIR
  } durum_e;

  logic [N-1:0]              kay_q, kay_d;
  logic [DW-1:0]             dolum_q, dolum_d;
  logic [N-1:0]              desen_q, desen_d;
  logic [N-1:0]              maske_q, maske_d;
  logic                      cikis_q, cikis_d;
  logic [SAYAC_GENISLIK-1:0] sayac_q, sayac_d;

  durum_e        durum;
  logic [N-1:0]  kay_yeni;
  logic [DW-1:0] dolum_yeni;
  logic          eslesme;

  always_ff @(posedge saat) begin
    if (reset) begin
      kay_q   <= '0;
      dolum_q <= '0;
      desen_q <= VARSAYILAN_DESEN;
      maske_q <= VARSAYILAN_MASKE;
      cikis_q <= 1'b0;
      sayac_q <= '0;
    end else begin
      kay_q   <= kay_d;
      dolum_q <= dolum_d;
      desen_q <= desen_d;
      maske_q <= maske_d;
      cikis_q <= cikis_d;
      sayac_q <= sayac_d;
    end
  end

  always_comb begin
    kay_yeni   = {kay_q[N-2:0], giris};
    dolum_yeni = (durum == HAZIR) ? DOLU : dolum_q + DW'(1);
    eslesme    = (dolum_yeni == DOLU) &&
                 (((kay_yeni ^ desen_q) & ~maske_q) == '0);

    kay_d   = kay_q;
    dolum_d = dolum_q;
    desen_d = desen_q;
    maske_d = maske_q;
    cikis_d = 1'b0;
    sayac_d = sayac_q;

    if (desen_yukle) begin
      desen_d = desen;
      maske_d = maske;
      kay_d   = '0;
      dolum_d = '0;
    end else if (gecerli) begin
      kay_d   = kay_yeni;
      dolum_d = dolum_yeni;
      if (eslesme) begin
        cikis_d = 1'b1;
        if (sayac_q != '1) sayac_d = sayac_q + 1'b1;
        // Non-overlap mode demands N fresh bits for the next hit
        if (!cakisma) dolum_d = '0;
      end
    end
  end

  always_comb begin
    durum = BOS;
    unique case (1'b1)
      (dolum_q == '0):   durum = BOS;
      (dolum_q == DOLU): durum = HAZIR;
      default:           durum = DOLUM;
    endcase
    cikis          = cikis_q;
    eslesme_sayisi = sayac_q;
    durum_no       = dolum_q;
  end

endmodule

// File: tb/tb_durum_desen_algilayici.sv
// Directed vector bench for durum_desen_algilayici.
module tb_durum_desen_algilayici;

  logic       saat = 1'b0;
  logic       reset = 1'b0;
  logic       giris = 1'b0;
  logic       gecerli = 1'b0;
  logic       cakisma = 1'b0;
  logic       desen_yukle = 1'b0;
  logic [3:0] desen = 4'b0;
  logic [3:0] maske = 4'b0;
  logic       cikis;
  logic [7:0] eslesme_sayisi;
  logic [2:0] durum_no;

  int napplied = 0;
  int nfail = 0;

  durum_desen_algilayici dut (
    .saat           (saat),
    .reset          (reset),
    .giris          (giris),
    .gecerli        (gecerli),
    .cakisma        (cakisma),
    .desen_yukle    (desen_yukle),
    .desen          (desen),
    .maske          (maske),
    .cikis          (cikis),
    .eslesme_sayisi (eslesme_sayisi),
    .durum_no       (durum_no)
  );

  always #5 saat = ~saat;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       vld;
    logic       ck;
    logic       g;
    logic [3:0] d;
    logic [3:0] m;
    logic       ec;
    logic [7:0] ecnt;
    logic [2:0] edur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic ld, input logic vld,
    input logic ck, input logic g,
    input logic [3:0] d, input logic [3:0] m,
    input logic ec, input logic [7:0] ecnt, input logic [2:0] edur);
    vec_t v;
    v.rst = rst; v.ld = ld; v.vld = vld; v.ck = ck; v.g = g;
    v.d = d; v.m = m; v.ec = ec; v.ecnt = ecnt; v.edur = edur;
    return v;
  endfunction

  task automatic bit_v(input logic ck, input logic g,
    input logic ec, input logic [7:0] ecnt, input logic [2:0] edur);
    vecs.push_back(mk(0, 0, 1, ck, g, 4'b0, 4'b0, ec, ecnt, edur));
  endtask

  task automatic gap_v(input logic ck,
    input logic ec, input logic [7:0] ecnt, input logic [2:0] edur);
    vecs.push_back(mk(0, 0, 0, ck, 0, 4'b0, 4'b0, ec, ecnt, edur));
  endtask

  task automatic rst_v(input logic ck);
    vecs.push_back(mk(1, 0, 0, ck, 0, 4'b0, 4'b0, 0, 8'd0, 3'd0));
  endtask

  task automatic ld_v(input logic ck, input logic [3:0] d,
    input logic [3:0] m, input logic [7:0] ecnt);
    vecs.push_back(mk(0, 1, 1, ck, 1, d, m, 0, ecnt, 3'd0));
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; desen_yukle = v.ld; gecerli = v.vld;
    cakisma = v.ck; giris = v.g; desen = v.d; maske = v.m;
    @(posedge saat);
    #1;
  endtask

  task automatic check(input string nm, input logic ec,
    input logic [7:0] ecnt, input logic [2:0] edur);
    napplied++;
    if (cikis !== ec || eslesme_sayisi !== ecnt || durum_no !== edur) begin
      nfail++;
      $display("FAIL %s: got cikis=%0b cnt=%0d durum=%0d, want cikis=%0b cnt=%0d durum=%0d",
               nm, cikis, eslesme_sayisi, durum_no, ec, ecnt, edur);
    end
  endtask

  initial begin
    // overlap, default pattern 1101
    rst_v(1);
    bit_v(1, 1, 0, 0, 1); bit_v(1, 1, 0, 0, 2); bit_v(1, 0, 0, 0, 3);
    bit_v(1, 1, 1, 1, 4); bit_v(1, 1, 0, 1, 4); bit_v(1, 0, 0, 1, 4);
    bit_v(1, 1, 1, 2, 4);
    // non-overlap
    rst_v(0);
    bit_v(0, 1, 0, 0, 1); bit_v(0, 1, 0, 0, 2); bit_v(0, 0, 0, 0, 3);
    bit_v(0, 1, 1, 1, 0); bit_v(0, 1, 0, 1, 1); bit_v(0, 0, 0, 1, 2);
    bit_v(0, 1, 0, 1, 3);
    // gaps
    rst_v(1);
    bit_v(1, 1, 0, 0, 1); bit_v(1, 1, 0, 0, 2);
    gap_v(1, 0, 0, 2); gap_v(1, 0, 0, 2); gap_v(1, 0, 0, 2);
    bit_v(1, 0, 0, 0, 3); bit_v(1, 1, 1, 1, 4);
    gap_v(1, 0, 1, 4);
    // reset beats load: default pattern must survive
    vecs.push_back(mk(1, 1, 1, 1, 1, 4'b0000, 4'b1111, 0, 0, 0));
    bit_v(1, 1, 0, 0, 1); bit_v(1, 1, 0, 0, 2); bit_v(1, 0, 0, 0, 3);
    bit_v(1, 1, 1, 1, 4);
    // masked pattern 1001 / 0110
    rst_v(1); ld_v(1, 4'b1001, 4'b0110, 0);
    bit_v(1, 1, 0, 0, 1); bit_v(1, 1, 0, 0, 2); bit_v(1, 1, 0, 0, 3);
    bit_v(1, 1, 1, 1, 4);
    rst_v(1); ld_v(1, 4'b1001, 4'b0110, 0);
    bit_v(1, 1, 0, 0, 1); bit_v(1, 0, 0, 0, 2); bit_v(1, 0, 0, 0, 3);
    bit_v(1, 1, 1, 1, 4);
    rst_v(1); ld_v(1, 4'b1001, 4'b0110, 0);
    bit_v(1, 0, 0, 0, 1); bit_v(1, 1, 0, 0, 2); bit_v(1, 1, 0, 0, 3);
    bit_v(1, 1, 0, 0, 4);
    // mid-stream reset restores 1101
    rst_v(1); ld_v(1, 4'b1111, 4'b0000, 0);
    bit_v(1, 1, 0, 0, 1); bit_v(1, 1, 0, 0, 2); bit_v(1, 0, 0, 0, 3);
    rst_v(1);
    bit_v(1, 1, 0, 0, 1);
    bit_v(1, 1, 0, 0, 2); bit_v(1, 0, 0, 0, 3); bit_v(1, 1, 1, 1, 4);
    // mid-stream load keeps the counter
    bit_v(1, 1, 0, 1, 4); bit_v(1, 1, 0, 1, 4); bit_v(1, 0, 0, 1, 4);
    ld_v(1, 4'b1101, 4'b0000, 1);
    bit_v(1, 1, 0, 1, 1);
    bit_v(1, 1, 0, 1, 2); bit_v(1, 0, 0, 1, 3); bit_v(1, 1, 1, 2, 4);
    // all-ones mask: every valid bit in HAZIR matches
    ld_v(1, 4'b0000, 4'b1111, 2);
    bit_v(1, 0, 0, 2, 1); bit_v(1, 1, 0, 2, 2); bit_v(1, 0, 0, 2, 3);
    bit_v(1, 1, 1, 3, 4); bit_v(1, 0, 1, 4, 4); gap_v(1, 0, 4, 4);
    bit_v(1, 1, 1, 5, 4);

    repeat (2) @(posedge saat);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ecnt, vecs[i].edur);
    end

    // saturation: 300 ones against 1111
    drive(mk(1, 0, 0, 1, 0, 4'b0, 4'b0, 0, 0, 0));
    check("sat_reset", 1'b0, 8'd0, 3'd0);
    drive(mk(0, 1, 0, 1, 0, 4'b1111, 4'b0000, 0, 0, 0));
    check("sat_load", 1'b0, 8'd0, 3'd0);
    for (int k = 1; k <= 300; k++) begin
      int exp_cnt;
      exp_cnt = (k < 4) ? 0 : ((k - 3 > 255) ? 255 : k - 3);
      drive(mk(0, 0, 1, 1, 1, 4'b0, 4'b0, 0, 0, 0));
      check($sformatf("sat_bit%0d", k), (k >= 4),
            8'(exp_cnt), 3'((k < 4) ? k : 4));
    end
    drive(mk(0, 0, 0, 1, 0, 4'b0, 4'b0, 0, 0, 0));
    check("sat_idle", 1'b0, 8'd255, 3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", napplied, nfail);
    $finish;
  end

endmodule

// File: doc/durum_desen_algilayici.md
Name: durum_desen_algilayici

Overview:
- Parametrised serial pattern detector (Moore FSM); next generation of the fixed single-pattern `durum` block.
- Pattern length is a parameter. Pattern and per-bit don't-care mask load at runtime.
- Supports a valid qualifier on the input bit, overlapping or non-overlapping match mode, and a saturating match counter.
- Sits between a serial bit source and lab-board LEDs/counters.

Parameters:
- N, 4, pattern length in bits (2..16).
- SAYAC_GENISLIK, 8, width of the match counter.
- VARSAYILAN_DESEN, 4'b1101, pattern register value after reset (N bits).
- VARSAYILAN_MASKE, 4'b0000, mask register value after reset (N bits, 1 = don't-care).

Ports:
- saat  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- giris  input  1  serial data bit.
- gecerli  input  1  giris is sampled only on edges where this is 1.
- cakisma  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- desen_yukle  input  1  load desen/maske into internal registers.
- desen  input  N  new pattern; desen[N-1] is the oldest (first received) bit, desen[0] the newest.
- maske  input  N  new don't-care mask, same bit ordering as desen.
- cikis  output  1  match pulse, exactly one cycle wide.
- eslesme_sayisi  output  SAYAC_GENISLIK  saturating count of matches.
- durum_no  output  $clog2(N+1)  current fill level, 0..N.

Behaviour:
- Clock and reset: one clock (saat); reset is synchronous and active-high.
- Internal registers:
  - kay: N-bit shift register.
  - dolum: fill counter, visible on durum_no.
  - desen_r, maske_r: pattern and mask registers.
- FSM states, derived from dolum:
  - BOS: dolum = 0.
  - DOLUM: 0 < dolum < N.
  - HAZIR: dolum = N.
- Priority per edge: reset > desen_yukle > gecerli.
- Reset edge:
  - kay = 0, dolum = 0 (BOS), cikis = 0, eslesme_sayisi = 0.
  - desen_r = VARSAYILAN_DESEN, maske_r = VARSAYILAN_MASKE.
- desen_yukle edge:
  - desen_r = desen, maske_r = maske; kay and dolum cleared; cikis = 0.
  - giris ignored on this edge; eslesme_sayisi unchanged.
- Valid edge (gecerli = 1, no reset/load):
  - kay_next = {kay[N-2:0], giris}.
  - dolum_next = min(dolum + 1, N).
  - Match when dolum_next == N and ((kay_next ^ desen_r) & ~maske_r) == 0.
- On match:
  - cikis = 1 for the following cycle only (registered; latency 1 cycle from the completing edge).
  - eslesme_sayisi increments, saturating at 2^SAYAC_GENISLIK - 1 with no wrap.
  - If cakisma = 0, dolum is set to 0 (BOS); the next match needs N fresh valid bits.
  - If cakisma = 1, dolum stays N; every further valid bit is evaluated.
- gecerli = 0 edge: kay, dolum and the counter hold; cikis = 0.
- cakisma is sampled on the matching edge itself; changing it mid-stream is legal.
- All-ones mask: every valid bit in HAZIR is a match.
- durum_no equals dolum; reads 0 in the cycle after reset, after a load, or after a non-overlapping match.
- No combinational path from inputs to outputs.

Test Plan:
1. Overlap: reset, cakisma=1, gecerli=1, default pattern 1101, stream 1,1,0,1,1,0,1 -> cikis high in the cycle after bit 4 and after bit 7 only; eslesme_sayisi = 2; durum_no = 4 at end.
2. Non-overlap: same stream with cakisma=0 -> cikis pulse after bit 4 only; durum_no = 3 after bit 7; eslesme_sayisi = 1.
3. Gaps: bits 1,1 then three cycles of gecerli=0 with giris=0, then 0,1 -> single one-cycle cikis pulse after the final bit; durum_no holds at 2 during the gap.
4. Mask: load desen=1001, maske=0110 -> streams 1111 and 1001 each produce a pulse (after reset between them); 0111 produces none; the load edge itself leaves durum_no = 0.
5. Saturation: desen=1111, maske=0000, cakisma=1, 300 consecutive valid 1s -> first pulse after bit 4; cikis stays high continuously; eslesme_sayisi stops at 255.
6. Mid-stream reset/load: bits 1,1,0, then reset, then bit 1 -> no pulse, durum_no = 1, desen_r back to 1101. Repeat with desen_yukle instead of reset -> same fill behaviour, counter unchanged.
